// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: turns command bytes from the UART RX byte interface into
// single-register read/write transactions on a 7-bit-address register bus.
// A command byte with bit7=1 is a write: the next byte is the data. A command
// byte with bit7=0 is a read: the register value is returned over UART TX.
// Optional feature macro WR_ACK_EN: after each completed write, send ACK_BYTE.
module uart_reg_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd50000
`ifdef WR_ACK_EN
  ,
  parameter logic [7:0]  ACK_BYTE = 8'hA5
`endif
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_RCAP,
    S_SEND,
    S_SWAIT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                seen_busy_q, seen_busy_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_overrun_q, err_overrun_d;

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      seen_busy_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_busy_q   <= seen_busy_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_we_q      <= reg_we_d;
      reg_re_q      <= reg_re_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Next-state and output decode for the command parser.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    seen_busy_d   = seen_busy_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_we_d      = 1'b0;
    reg_re_d      = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          reg_addr_d = rx_data[ADDR_W-1:0];
          if (rx_data[7]) begin
            state_d = S_WDATA;
          end else begin
            reg_re_d = 1'b1;
            state_d  = S_RCAP;
          end
        end
      end

      S_WDATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rx_valid) begin
          // A byte arriving on the expiry cycle still completes the write.
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
`ifdef WR_ACK_EN
          tx_data_d   = ACK_BYTE;
          state_d     = S_SEND;
`else
          state_d     = S_IDLE;
`endif
        end else if (cnt_q == TIMEOUT - CNT_W'(1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_RCAP: begin
        err_overrun_d = rx_valid;
        // First RCAP cycle carries reg_re; read data is valid on the second,
        // where it is captured and the transmit request is issued directly
        // when the UART is free so the response starts three cycles after
        // the command byte.
        if (!reg_re_q) begin
          tx_data_d = reg_rdata;
          if (!tx_busy) begin
            tx_start_d  = 1'b1;
            seen_busy_d = 1'b0;
            state_d     = S_SWAIT;
          end else begin
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        err_overrun_d = rx_valid;
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_SWAIT;
        end
      end

      S_SWAIT: begin
        err_overrun_d = rx_valid;
        // busy only rises the cycle after tx_start, so require a high first.
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
